alu_req_arbiter: RTL

- Shares one combinational 8-bit ALU (a, b, 3-bit opcode -> 8-bit out) between two requesters.
- Round-robin arbitration; accepted operands are registered and driven to the ALU; the result is captured after a configurable settle time.
- The result is returned on a single valid/ready response channel tagged with the requester id.
- Sits between the two operand sources and the shared ALU instance. Opcode-agnostic: the opcode passes straight through to the ALU.

---
 rtl/alu_req_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Operands are registered toward the ALU, and the result is returned on a valid/ready channel tagged with the requester id.
module alu_req_arbiter #(
    parameter int DW      = 8,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_out,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DW-1:0]  rsp_data,
    output logic           rsp_id,
    output logic           busy,
    output logic [7:0]     done_cnt
);

    // state   | meaning
    // ST_IDLE | arbitrating; ready is offered only to the winner
    // ST_WAIT | operands held on the ALU while the settle counter runs
    // ST_RESP | result held on the response channel until it is taken
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int            CW     = 4;
    localparam logic [CW-1:0] LAT_TC = CW'(ALU_LAT - 1);

    logic [1:0]    state;
    logic          last_grant;
    logic [CW-1:0] wait_cnt;
    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          win_id;

    // On a tie, the requester that was not served last wins.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant);
        grant1 = req1_valid && (!req0_valid || !last_grant);
    end

    assign req0_ready = (state == ST_IDLE) && grant0;
    assign req1_ready = (state == ST_IDLE) && grant1;
    assign accept     = req0_ready || req1_ready;
    assign win_id     = req1_ready;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            done_cnt   <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        alu_a      <= win_id ? req1_a  : req0_a;
                        alu_b      <= win_id ? req1_b  : req0_b;
                        alu_op     <= win_id ? req1_op : req0_op;
                        rsp_id     <= win_id;
                        last_grant <= win_id;
                        wait_cnt   <= '0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == LAT_TC) begin
                        rsp_data  <= alu_out;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + 8'd1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
